// File: rtl/sw_dat_sync_deb_if.sv
// Switch front-end bus: raw switch bank and hold in, published word, strobe and settle flag out.
interface sw_dat_sync_deb_if #(
    parameter int SW_WIDTH  = 7,
    parameter int DAT_WIDTH = 16
);
    logic [SW_WIDTH-1:0]  SW;
    logic                 hold;
    logic [DAT_WIDTH-1:0] dat;
    logic                 dat_stb;
    logic                 stable;

    modport master (output SW, hold, input dat, dat_stb, stable);
    modport slave  (input SW, hold, output dat, dat_stb, stable);
endinterface

// File: rtl/sw_dat_sync_deb.sv
// Switch bank front end: two-FF synchroniser, whole-vector debouncer and
// zero/sign extension to a published data word with a change strobe.
module sw_dat_sync_deb #(
    parameter int SW_WIDTH   = 7,
    parameter int DAT_WIDTH  = 16,
    parameter int DEB_CYCLES = 50000,
    parameter int SIGN_EXT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    sw_dat_sync_deb_if.slave   bus
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    if (DAT_WIDTH < SW_WIDTH) begin : g_bad_width
        $error("sw_dat_sync_deb: DAT_WIDTH must be >= SW_WIDTH");
    end
    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("sw_dat_sync_deb: DEB_CYCLES must be >= 2");
    end

    logic [SW_WIDTH-1:0]  s1;
    logic [SW_WIDTH-1:0]  sw_s;
    logic [SW_WIDTH-1:0]  cand;
    logic [SW_WIDTH-1:0]  deb;
    logic [CW-1:0]        cnt;
    logic                 stable_q;
    logic [DAT_WIDTH-1:0] ext;
    logic [DAT_WIDTH-1:0] dat_q;
    logic                 stb_q;

    // Any bit change restarts the count for the whole vector; the count saturates once settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            sw_s     <= '0;
            cand     <= '0;
            deb      <= '0;
            cnt      <= '0;
            stable_q <= 1'b0;
        end else begin
            s1   <= bus.SW;
            sw_s <= s1;
            if (sw_s != cand) begin
                cand     <= sw_s;
                cnt      <= '0;
                stable_q <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                deb      <= cand;
                stable_q <= 1'b1;
            end
        end
    end

    always_comb begin
        if (SIGN_EXT != 0)
            ext = DAT_WIDTH'($signed(deb));
        else
            ext = DAT_WIDTH'(deb);
    end

    // The low SW_WIDTH bits of dat are the last published switch value, so no shadow copy is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
            stb_q <= 1'b0;
        end else if (!bus.hold && (deb != dat_q[SW_WIDTH-1:0])) begin
            dat_q <= ext;
            stb_q <= 1'b1;
        end else begin
            stb_q <= 1'b0;
        end
    end

    assign bus.dat     = dat_q;
    assign bus.dat_stb = stb_q;
    assign bus.stable  = stable_q;
endmodule

// File: tb/tb_sw_dat_sync_deb.sv
// Bench for sw_dat_sync_deb: zero- and sign-extending instances checked every cycle
// against a run-length model, plus directed literal checkpoints.
module tb_sw_dat_sync_deb;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [6:0] sw;
    logic       hold;

    int vectors     = 0;
    int miscompares = 0;
    int stb_total   = 0;
    int base;
    bit armed = 0;

    sw_dat_sync_deb_if #(.SW_WIDTH(7), .DAT_WIDTH(16)) bus0 ();
    sw_dat_sync_deb_if #(.SW_WIDTH(7), .DAT_WIDTH(16)) bus1 ();

    assign bus0.SW   = sw;
    assign bus0.hold = hold;
    assign bus1.SW   = sw;
    assign bus1.hold = hold;

    sw_dat_sync_deb #(.SW_WIDTH(7), .DAT_WIDTH(16), .DEB_CYCLES(D), .SIGN_EXT(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    sw_dat_sync_deb #(.SW_WIDTH(7), .DAT_WIDTH(16), .DEB_CYCLES(D), .SIGN_EXT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] extend(input logic [6:0] v, input bit sgn);
        int unsigned val;
        val = v;
        if (sgn && v >= 7'd64) val = val + 32'd65536 - 32'd128;
        return val[15:0];
    endfunction

    // Model: a value is accepted once the debouncer has seen it D+1 edges in a row;
    // the debouncer sees raw samples two edges late, with zeros right after reset.
    logic [6:0]  xq[$];
    int          run;
    logic [6:0]  ylast, mdeb;
    logic [15:0] mdat0, mdat1;
    logic        mstb, mstab;

    always @(posedge clk) begin
        if (rst) begin
            xq.delete();
            run   = 1;
            ylast = '0;
            mdeb  = '0;
            mdat0 = '0;
            mdat1 = '0;
            mstb  = 1'b0;
            mstab = 1'b0;
            armed = 1'b1;
        end else begin
            logic [6:0] y;
            logic [6:0] prev;
            prev = mdeb;
            y = (xq.size() >= 2) ? xq[xq.size()-2] : 7'h00;
            xq.push_back(sw);
            if (xq.size() > 2) void'(xq.pop_front());
            if (y == ylast) begin
                if (run < 1000) run++;
            end else begin
                run   = 1;
                ylast = y;
            end
            mstab = (run >= D + 1);
            if (mstab) mdeb = y;
            if (!hold && prev != mdat0[6:0]) begin
                mdat0 = extend(prev, 1'b0);
                mdat1 = extend(prev, 1'b1);
                mstb  = 1'b1;
            end else begin
                mstb  = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("dat0",    bus0.dat,            mdat0);
            chk("dat1",    bus1.dat,            mdat1);
            chk("stb0",    16'(bus0.dat_stb),   16'(mstb));
            chk("stb1",    16'(bus1.dat_stb),   16'(mstb));
            chk("stable0", 16'(bus0.stable),    16'(mstab));
            chk("stable1", 16'(bus1.stable),    16'(mstab));
            if (bus0.dat_stb) stb_total++;
        end
    end

    initial begin
        rst  = 1'b1;
        sw   = '0;
        hold = 1'b0;
        cyc(2);
        chk("reset_dat", bus0.dat, 16'h0000);
        chk("reset_stable", 16'(bus0.stable), 16'h0);

        // Out of reset with SW=05: publish at edge 8
        rst = 1'b0; sw = 7'h05;
        cyc(6); chk("t1_stable_e6", 16'(bus0.stable), 16'h0);
        cyc(1); chk("t1_dat_e7", bus0.dat, 16'h0000);
                chk("t1_stable_e7", 16'(bus0.stable), 16'h1);
        cyc(1); chk("t1_dat_e8", bus0.dat, 16'h0005);
                chk("t1_stb_e8", 16'(bus0.dat_stb), 16'h1);
                chk("t1_dat1_e8", bus1.dat, 16'h0005);
        cyc(1); chk("t1_stb_e9", 16'(bus0.dat_stb), 16'h0);

        // Bounce 05/00 every 2 clk, then settle on 05
        rst = 1'b1; cyc(2); rst = 1'b0;
        base = stb_total;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 7'h05 : 7'h00;
            cyc(2);
        end
        chk("t2_no_stb_bounce", 16'(stb_total - base), 16'h0);
        sw = 7'h05;
        cyc(7); chk("t2_dat_e7", bus0.dat, 16'h0000);
        cyc(1); chk("t2_dat_e8", bus0.dat, 16'h0005);
                chk("t2_stb_e8", 16'(bus0.dat_stb), 16'h1);
                chk("t2_stb_count", 16'(stb_total - base), 16'h1);

        // Extension: zero vs sign
        sw = 7'h40;
        cyc(8); chk("t3_dat0_40", bus0.dat, 16'h0040);
                chk("t3_dat1_40", bus1.dat, 16'hFFC0);
        sw = 7'h7F;
        cyc(8); chk("t3_dat0_7f", bus0.dat, 16'h007F);
                chk("t3_dat1_7f", bus1.dat, 16'hFFFF);

        // Hold freezes dat; release publishes the final value once
        sw = 7'h05;
        cyc(10); chk("t4_dat_pre", bus0.dat, 16'h0005);
        hold = 1'b1; sw = 7'h12; base = stb_total;
        cyc(20); chk("t4_dat_held", bus0.dat, 16'h0005);
                 chk("t4_no_stb_hold", 16'(stb_total - base), 16'h0);
                 chk("t4_stable_hold", 16'(bus0.stable), 16'h1);
        hold = 1'b0;
        cyc(1); chk("t4_dat_rel", bus0.dat, 16'h0012);
                chk("t4_stb_rel", 16'(bus0.dat_stb), 16'h1);
        cyc(1); chk("t4_stb_after", 16'(bus0.dat_stb), 16'h0);
                chk("t4_stb_count", 16'(stb_total - base), 16'h1);

        // Reset mid-debounce discards progress
        sw = 7'h05;
        cyc(10); chk("t5_dat_pre", bus0.dat, 16'h0005);
        sw = 7'h0A;
        cyc(2); rst = 1'b1;
        cyc(2); chk("t5_dat_rst", bus0.dat, 16'h0000);
                chk("t5_stable_rst", 16'(bus0.stable), 16'h0);
        rst = 1'b0; base = stb_total;
        cyc(7); chk("t5_dat_e7", bus0.dat, 16'h0000);
        cyc(1); chk("t5_dat_e8", bus0.dat, 16'h000A);
                chk("t5_stb_e8", 16'(bus0.dat_stb), 16'h1);
                chk("t5_stb_count", 16'(stb_total - base), 16'h1);

        // Glitch back to the old value: no strobe, stable re-settles
        sw = 7'h05;
        cyc(10); chk("t6_dat_pre", bus0.dat, 16'h0005);
        base = stb_total; sw = 7'h07;
        cyc(2); chk("t6_stable_e2", 16'(bus0.stable), 16'h1);
        sw = 7'h05;
        cyc(1); chk("t6_stable_e3", 16'(bus0.stable), 16'h0);
        cyc(5); chk("t6_stable_e8", 16'(bus0.stable), 16'h0);
        cyc(1); chk("t6_stable_e9", 16'(bus0.stable), 16'h1);
        cyc(5); chk("t6_dat_end", bus0.dat, 16'h0005);
                chk("t6_no_stb", 16'(stb_total - base), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
